// File: rtl/fsm_aspiradora_ctrl.sv
// Robot vacuum controller: 6-state Moore FSM driving suction/drive enables, with timed cleaning/evasion and docking.
// Optional stall detection (evasion retry limit with fault flag) is enabled by defining ASPI_STALL_DETECT_EN.
module fsm_aspiradora_ctrl #(
    parameter int N_BUMP    = 4,
    parameter int BAT_W     = 8,
    parameter int BAT_LOW   = 32,
    parameter int BAT_FULL  = 240,
    parameter int CLEAN_MIN = 16,
    parameter int EVADE_CYC = 8,
    parameter int CNT_W     = 8,
    parameter int MAX_RETRY = 3
) (
    input  logic              clk,
    input  logic              power_off_n,
    input  logic              on,
    input  logic              dirt,
    input  logic [N_BUMP-1:0] bump,
    input  logic [BAT_W-1:0]  battery,
    input  logic              docked,
    output logic [2:0]        state,
    output logic              suction_en,
    output logic              drive_en,
    output logic              turn_dir,
    output logic [CNT_W-1:0]  spot_count,
    output logic              fault
);

    typedef enum logic [2:0] {
        S_OFF       = 3'b000,
        S_EXPLORING = 3'b001,
        S_CLEANING  = 3'b010,
        S_EVADING   = 3'b011,
        S_DOCKING   = 3'b100,
        S_CHARGING  = 3'b101
    } state_t;

    localparam int TMAX = (CLEAN_MIN > EVADE_CYC) ? CLEAN_MIN : EVADE_CYC;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int HALF = N_BUMP / 2;

    state_t           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             turn_q, turn_d;
    logic [CNT_W-1:0] spot_q, spot_d;
    logic             fault_q, fault_d;
    logic             load_evade, load_clean;

    logic low, hit, left_hit, timer_zero;
    assign low        = battery < BAT_W'(BAT_LOW);
    assign hit        = |bump;
    assign left_hit   = |bump[HALF-1:0];
    assign timer_zero = (timer_q == '0);

`ifdef ASPI_STALL_DETECT_EN
    localparam int RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RW-1:0] retry_q, retry_d;
`endif

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        turn_d     = turn_q;
        spot_d     = spot_q;
        fault_d    = fault_q;
        load_evade = 1'b0;
        load_clean = 1'b0;
`ifdef ASPI_STALL_DETECT_EN
        retry_d    = retry_q;
`endif
        if ((state_q == S_CLEANING || state_q == S_EVADING) && !timer_zero)
            timer_d = timer_q - TW'(1);

        case (state_q)
            S_OFF: begin
                if (on && !fault_q)
                    state_d = S_EXPLORING;
            end
            S_EXPLORING: begin
                if (!on)
                    state_d = S_OFF;
                else if (low)
                    state_d = S_DOCKING;
                else if (hit) begin
                    state_d    = S_EVADING;
                    load_evade = 1'b1;
`ifdef ASPI_STALL_DETECT_EN
                    retry_d    = '0;
`endif
                end else if (dirt) begin
                    state_d    = S_CLEANING;
                    load_clean = 1'b1;
                end
            end
            S_CLEANING: begin
                if (!on)
                    state_d = S_OFF;
                else if (low)
                    state_d = S_DOCKING;
                else if (hit) begin
                    state_d    = S_EVADING;
                    load_evade = 1'b1;
`ifdef ASPI_STALL_DETECT_EN
                    retry_d    = '0;
`endif
                end else if (timer_zero && !dirt) begin
                    state_d = S_EXPLORING;
                    if (spot_q != '1)
                        spot_d = spot_q + CNT_W'(1);
                end
            end
            S_EVADING: begin
                if (!on)
                    state_d = S_OFF;
                else if (timer_zero) begin
                    if (hit) begin
`ifdef ASPI_STALL_DETECT_EN
                        // A reload that would reach the retry limit means we are stuck.
                        if (int'(retry_q) + 1 == MAX_RETRY) begin
                            state_d = S_OFF;
                            fault_d = 1'b1;
                        end else begin
                            load_evade = 1'b1;
                            retry_d    = retry_q + RW'(1);
                        end
`else
                        load_evade = 1'b1;
`endif
                    end else if (low)
                        state_d = S_DOCKING;
                    else
                        state_d = S_EXPLORING;
                end
            end
            S_DOCKING: begin
                if (!on)
                    state_d = S_OFF;
                else if (docked)
                    state_d = S_CHARGING;
            end
            S_CHARGING: begin
                if (!on)
                    state_d = S_OFF;
                else if (battery >= BAT_W'(BAT_FULL))
                    state_d = S_EXPLORING;
                else if (!docked)
                    state_d = S_DOCKING;
            end
            default: state_d = S_OFF;
        endcase

        if (load_evade) begin
            timer_d = TW'(EVADE_CYC - 1);
            turn_d  = left_hit;
        end
        if (load_clean)
            timer_d = TW'(CLEAN_MIN - 1);
`ifdef ASPI_STALL_DETECT_EN
        if (!on)
            fault_d = 1'b0;
`else
        fault_d = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge power_off_n) begin
        if (!power_off_n) begin
            state_q <= S_OFF;
            timer_q <= '0;
            turn_q  <= 1'b0;
            spot_q  <= '0;
            fault_q <= 1'b0;
`ifdef ASPI_STALL_DETECT_EN
            retry_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            turn_q  <= turn_d;
            spot_q  <= spot_d;
            fault_q <= fault_d;
`ifdef ASPI_STALL_DETECT_EN
            retry_q <= retry_d;
`endif
        end
    end

    assign state      = state_q;
    assign suction_en = (state_q == S_CLEANING);
    assign drive_en   = (state_q == S_EXPLORING) || (state_q == S_CLEANING) ||
                        (state_q == S_EVADING)   || (state_q == S_DOCKING);
    assign turn_dir   = turn_q;
    assign spot_count = spot_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_fsm_aspiradora_ctrl.sv
// Self-checking bench for fsm_aspiradora_ctrl: a vector table for single-cycle transitions plus
// hand-written sequences for cleaning/evasion timing, docking, async reset and (if enabled) stall detection.
module tb_fsm_aspiradora_ctrl;

    logic       clk = 1'b0;
    logic       power_off_n;
    logic       on;
    logic       dirt;
    logic [3:0] bump;
    logic [7:0] battery;
    logic       docked;
    logic [2:0] st;
    logic       suction_en;
    logic       drive_en;
    logic       turn_dir;
    logic [7:0] spot_count;
    logic       fault;

    int checks = 0;
    int errors = 0;

    fsm_aspiradora_ctrl dut (
        .clk        (clk),
        .power_off_n(power_off_n),
        .on         (on),
        .dirt       (dirt),
        .bump       (bump),
        .battery    (battery),
        .docked     (docked),
        .state      (st),
        .suction_en (suction_en),
        .drive_en   (drive_en),
        .turn_dir   (turn_dir),
        .spot_count (spot_count),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       on;
        logic       dirt;
        logic [3:0] bump;
        logic [7:0] battery;
        logic       docked;
        logic [2:0] st;
        logic       suc;
        logic       drv;
        logic       tdir;
        logic [7:0] spot;
    } vec_t;

    vec_t vecs[13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        on      = v.on;
        dirt    = v.dirt;
        bump    = v.bump;
        battery = v.battery;
        docked  = v.docked;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Dirt pulse from EXPLORING; returns how many cycles were spent in CLEANING.
    task automatic cleanOnce(output int cycles);
        dirt = 1'b1;
        tick();
        dirt = 1'b0;
        cycles = 0;
        while (st == 3'b010 && cycles < 100) begin
            cycles++;
            tick();
        end
    endtask

    // Bump pattern held for 'hold' edges starting from EXPLORING; counts EVADING cycles.
    task automatic evadeRun(input logic [3:0] pat, input int hold, output int cycles, output logic tdir_first);
        bump = pat;
        tick();
        tdir_first = turn_dir;
        cycles = 0;
        while (st == 3'b011 && cycles < 64) begin
            cycles++;
            bump = (cycles < hold) ? pat : 4'b0000;
            tick();
        end
        bump = 4'b0000;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   cyc;
        int   bad;
        logic td;

        //                 on    dirt  bump     bat     dock  st      suc   drv   tdir  spot
        vecs[0]  = '{1'b1, 1'b0, 4'b0000, 8'd100, 1'b0, 3'b001, 1'b0, 1'b1, 1'b0, 8'd0};
        vecs[1]  = '{1'b1, 1'b0, 4'b0100, 8'd20,  1'b0, 3'b100, 1'b0, 1'b1, 1'b0, 8'd0};
        vecs[2]  = '{1'b1, 1'b0, 4'b0000, 8'd20,  1'b1, 3'b101, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[3]  = '{1'b1, 1'b0, 4'b0000, 8'd20,  1'b0, 3'b100, 1'b0, 1'b1, 1'b0, 8'd0};
        vecs[4]  = '{1'b1, 1'b0, 4'b0000, 8'd20,  1'b1, 3'b101, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[5]  = '{1'b1, 1'b0, 4'b0000, 8'd240, 1'b1, 3'b001, 1'b0, 1'b1, 1'b0, 8'd0};
        vecs[6]  = '{1'b1, 1'b1, 4'b0011, 8'd100, 1'b0, 3'b011, 1'b0, 1'b1, 1'b1, 8'd0};
        vecs[7]  = '{1'b0, 1'b0, 4'b0000, 8'd100, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 8'd0};
        vecs[8]  = '{1'b1, 1'b1, 4'b0000, 8'd100, 1'b0, 3'b001, 1'b0, 1'b1, 1'b1, 8'd0};
        vecs[9]  = '{1'b1, 1'b1, 4'b0000, 8'd100, 1'b0, 3'b010, 1'b1, 1'b1, 1'b1, 8'd0};
        vecs[10] = '{1'b1, 1'b0, 4'b1000, 8'd100, 1'b0, 3'b011, 1'b0, 1'b1, 1'b0, 8'd0};
        vecs[11] = '{1'b0, 1'b0, 4'b0000, 8'd100, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[12] = '{1'b1, 1'b0, 4'b0000, 8'd100, 1'b0, 3'b001, 1'b0, 1'b1, 1'b0, 8'd0};

        power_off_n = 1'b0;
        on = 1'b1; dirt = 1'b0; bump = 4'b0000; battery = 8'd100; docked = 1'b0;
        tick();
        tick();
        checkOutput("reset state", int'(st), 0);
        checkOutput("reset spot", int'(spot_count), 0);
        checkOutput("reset turn_dir", int'(turn_dir), 0);
        checkOutput("reset fault", int'(fault), 0);
        checkOutput("reset drive_en", int'(drive_en), 0);
        #3 power_off_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i]);
            tick();
            checkOutput($sformatf("vec%0d state", i), int'(st), int'(vecs[i].st));
            checkOutput($sformatf("vec%0d suction", i), int'(suction_en), int'(vecs[i].suc));
            checkOutput($sformatf("vec%0d drive", i), int'(drive_en), int'(vecs[i].drv));
            checkOutput($sformatf("vec%0d turn_dir", i), int'(turn_dir), int'(vecs[i].tdir));
            checkOutput($sformatf("vec%0d spot", i), int'(spot_count), int'(vecs[i].spot));
        end

        $display("[TB] cleaning dwell and spot counter saturation");
        cleanOnce(cyc);
        checkOutput("clean dwell", cyc, 16);
        checkOutput("clean exit state", int'(st), 1);
        checkOutput("spot after first", int'(spot_count), 1);
        bad = 0;
        for (int i = 1; i < 300; i++) begin
            cleanOnce(cyc);
            if (cyc != 16 || st != 3'b001) bad++;
            if (i == 254) checkOutput("spot at 255th", int'(spot_count), 255);
        end
        checkOutput("clean loop bad dwells", bad, 0);
        checkOutput("spot saturated", int'(spot_count), 255);

        dirt = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        checkOutput("dirt held state", int'(st), 2);
        dirt = 1'b0;
        tick();
        checkOutput("dirt released state", int'(st), 1);
        checkOutput("spot stays saturated", int'(spot_count), 255);

        $display("[TB] evasion timing and reload");
        evadeRun(4'b0001, 1, cyc, td);
        checkOutput("evade left turn_dir", int'(td), 1);
        checkOutput("evade single cycles", cyc, 8);
        checkOutput("evade single exit", int'(st), 1);
        evadeRun(4'b1100, 12, cyc, td);
        checkOutput("evade right turn_dir", int'(td), 0);
        checkOutput("evade reload cycles", cyc, 16);
        checkOutput("evade reload exit", int'(st), 1);
        checkOutput("turn_dir holds", int'(turn_dir), 0);

        $display("[TB] low battery during evasion, docking and charging");
        bump = 4'b0001;
        tick();
        bump = 4'b0000;
        battery = 8'd20;
        for (int i = 0; i < 7; i++) tick();
        checkOutput("evade ignores low", int'(st), 3);
        tick();
        checkOutput("evade to docking", int'(st), 4);
        docked = 1'b1;
        tick();
        checkOutput("dock to charging", int'(st), 5);
        battery = 8'd239;
        tick();
        checkOutput("charging at 239", int'(st), 5);
        battery = 8'd240;
        tick();
        checkOutput("charging done", int'(st), 1);
        battery = 8'd20;
        tick();
        checkOutput("explore low", int'(st), 4);
        tick();
        checkOutput("redock", int'(st), 5);
        docked = 1'b0;
        tick();
        checkOutput("undock to docking", int'(st), 4);
        docked = 1'b1;
        battery = 8'd240;
        tick();
        tick();
        checkOutput("back exploring", int'(st), 1);
        docked = 1'b0;
        battery = 8'd100;

        $display("[TB] asynchronous reset mid-clean");
        dirt = 1'b1;
        tick();
        dirt = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        checkOutput("pre-reset state", int'(st), 2);
        checkOutput("pre-reset timer", int'(dut.timer_q), 7);
        #2 power_off_n = 1'b0;
        #1;
        checkOutput("async reset state", int'(st), 0);
        checkOutput("async reset spot", int'(spot_count), 0);
        checkOutput("async reset timer", int'(dut.timer_q), 0);
        #1 power_off_n = 1'b1;
        tick();
        checkOutput("release to exploring", int'(st), 1);
        bump = 4'b0001;
        tick();
        checkOutput("evade before off", int'(st), 3);
        bump = 4'b0000;
        on = 1'b0;
        tick();
        checkOutput("on low in evading", int'(st), 0);
        on = 1'b1;
        tick();
        checkOutput("restart exploring", int'(st), 1);

`ifdef ASPI_STALL_DETECT_EN
        $display("[TB] stall detection");
        evadeRun(4'b0001, 1000, cyc, td);
        checkOutput("stall evade cycles", cyc, 24);
        checkOutput("stall state", int'(st), 0);
        checkOutput("stall fault", int'(fault), 1);
        tick();
        checkOutput("fault blocks on", int'(st), 0);
        on = 1'b0;
        tick();
        checkOutput("fault cleared", int'(fault), 0);
        on = 1'b1;
        tick();
        checkOutput("restart after fault", int'(st), 1);
`else
        checkOutput("fault tied low", int'(fault), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
